pll_lock_supervisor: RTL and testbench
======================================

// Module: pll_lock_supervisor
// PURPOSE
//  Consumer side of the PLL wrapper's rst/locked interface: drives the PLL's rst input and
//  watches its locked output, all in the refclk (50 MHz) domain. Sequences PLL reset, waits
//  for lock with timeout/retry, qualifies lock stability and holds the downstream system
//  reset (for the 40/25/0.8 MHz domains) until lock is stable. Re-runs the sequence on
//  lock loss or on restart.
// PARAMETERS
//  RST_CYCLES     16     pll_rst assertion width, refclk cycles (>=1)
//  LOCK_TIMEOUT   50000  max cycles in WAIT_LOCK before a retry (1 ms @ 50 MHz)
//  STABLE_CYCLES  1024   consecutive synced-locked cycles required before release
//  MAX_RETRIES    4      consecutive lock timeouts tolerated before FAIL
//  CNT_W          8      width of retry_cnt / loss_cnt
// PORTS
//  refclk     in   1      free-running 50 MHz reference clock
//  rst        in   1      async active-high reset; deassertion assumed refclk-synchronous
//  pll_locked in   1      PLL locked, asynchronous to refclk
//  restart    in   1      1-cycle pulse; forces a full PLL re-sequence
//  pll_rst    out  1      drives PLL rst
//  sys_rst    out  1      active-high reset for downstream clock domains
//  ready      out  1      1 only in RUN
//  fail       out  1      1 only in FAIL (sticky until rst/restart)
//  retry_cnt  out  CNT_W  lock timeouts since the last RUN entry, saturating
//  loss_cnt   out  CNT_W  RUN->lock-loss events since rst, saturating
// BEHAVIOUR
//  Reset (rst=1): state=RESET_PLL, timer=0, pll_rst=1, sys_rst=1, ready=0, fail=0,
//   counters=0, synchroniser flops=0. All outputs are registered.
//  pll_locked passes a 2-flop synchroniser -> lk; 2 cycles latency, no filtering beyond it.
//  Single timer shared by states; cleared on every state change.
//  States / transitions (evaluated each refclk edge):
//   RESET_PLL: pll_rst=1, sys_rst=1. Stays exactly RST_CYCLES cycles, then WAIT_LOCK.
//   WAIT_LOCK: pll_rst=0, sys_rst=1. lk=1 -> STABLE. timer==LOCK_TIMEOUT-1 with lk=0 ->
//     retry_cnt+1 (saturate); if the new retry_cnt==MAX_RETRIES -> FAIL, else RESET_PLL.
//   STABLE: pll_rst=0, sys_rst=1. lk=0 -> WAIT_LOCK (timer cleared, retry_cnt unchanged).
//     timer==STABLE_CYCLES-1 with lk=1 -> RUN.
//   RUN: pll_rst=0, sys_rst=0, ready=1. retry_cnt cleared on entry.
//     lk=0 -> loss_cnt+1 (saturate), RESET_PLL.
//   FAIL: pll_rst=1, sys_rst=1, fail=1. Leaves only on restart (-> RESET_PLL) or rst.
//  restart=1 in any state -> RESET_PLL next cycle, timer=0, retry_cnt=0, fail=0;
//   loss_cnt kept. restart takes priority over every other transition in the same cycle.
//  Output timing: sys_rst deasserts and ready asserts on the same edge that enters RUN;
//   sys_rst reasserts on the edge that leaves RUN. lk drop to sys_rst=1 is 1 cycle;
//   pll_locked pin drop to sys_rst=1 is 3 cycles.
//  Counters saturate at 2^CNT_W-1 and do not wrap.
//  Glitch: a lk low pulse of any length in RUN is a loss, with no debounce.
//  rst mid-sequence aborts immediately and asynchronously to the reset values.
// TESTING (bench params: RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8, MAX_RETRIES=2)
//  1 rst release, pll_locked=1 from cycle 6 -> pll_rst high for cycles 0-3; ready=1 and
//    sys_rst=0 at a fixed, checked cycle (lock + 2 sync + 8 stable); retry_cnt=0.
//  2 pll_locked held 0 -> two 20-cycle WAIT_LOCK windows, retry_cnt=1 then 2, fail=1,
//    pll_rst=1 steady; restart pulse -> fail=0, retry_cnt=0, new 4-cycle pll_rst pulse.
//  3 In STABLE, drop pll_locked for 1 cycle at timer=5 -> back to WAIT_LOCK; a full 8
//    cycles are required again before RUN.
//  4 In RUN, 1-cycle pll_locked low -> sys_rst=1 and ready=0 3 cycles after the pin drop;
//    loss_cnt=1; sequence restarts with a 4-cycle pll_rst.
//  5 CNT_W=2, force 5 losses -> loss_cnt saturates at 3.
//  6 Assert rst mid-WAIT_LOCK and restart coincident with a timeout -> reset values seen
//    immediately; restart wins (RESET_PLL, retry_cnt=0, fail=0).

Source files
------------

// File: rtl/pll_lock_supervisor_if.sv
// ============================================================================
// Module      : pll_lock_supervisor_if
// Description : Control and status bundle between the PLL lock supervisor and
//               its surroundings. It carries the PLL lock input, the restart
//               request, the PLL reset drive, the downstream system reset and
//               the status flags and counters.
//               master : supervisor side (drives pll_rst / sys_rst / status)
//               slave  : environment side (drives pll_locked / restart)
// Signals     : pll_locked  PLL locked indication, asynchronous to refclk
//               restart     1-cycle pulse, forces a full PLL re-sequence
//               pll_rst     drives the PLL rst input
//               sys_rst     active-high reset for the downstream clock domains
//               ready       high only while the supervisor is in RUN
//               fail        high only while the supervisor is in FAIL
//               retry_cnt   lock timeouts since the last RUN entry (saturating)
//               loss_cnt    RUN lock-loss events since rst (saturating)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pll_lock_supervisor_if #(
    parameter int CNT_W = 8
) ();
    logic             pll_locked;
    logic             restart;
    logic             pll_rst;
    logic             sys_rst;
    logic             ready;
    logic             fail;
    logic [CNT_W-1:0] retry_cnt;
    logic [CNT_W-1:0] loss_cnt;

    modport master (
        input  pll_locked,
        input  restart,
        output pll_rst,
        output sys_rst,
        output ready,
        output fail,
        output retry_cnt,
        output loss_cnt
    );

    modport slave (
        output pll_locked,
        output restart,
        input  pll_rst,
        input  sys_rst,
        input  ready,
        input  fail,
        input  retry_cnt,
        input  loss_cnt
    );
endinterface

`default_nettype wire

// File: rtl/pll_lock_supervisor.sv
// ============================================================================
// Module      : pll_lock_supervisor
// Description : Sequences the PLL reset, waits for lock with timeout/retry,
//               qualifies lock stability and holds the downstream system
//               reset until the lock has been stable long enough. Re-runs
//               the sequence on lock loss or on a restart request. Runs
//               entirely in the refclk domain; pll_locked is synchronised
//               with a 2-flop synchroniser.
// Ports       : refclk  free-running reference clock
//               rst     asynchronous active-high reset (refclk-synchronous
//                       deassertion assumed)
//               sup     pll_lock_supervisor_if.master
//                       (pll_locked, restart in; pll_rst, sys_rst, ready,
//                        fail, retry_cnt, loss_cnt out)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pll_lock_supervisor #(
    parameter int RST_CYCLES    = 16,
    parameter int LOCK_TIMEOUT  = 50000,
    parameter int STABLE_CYCLES = 1024,
    parameter int MAX_RETRIES   = 4,
    parameter int CNT_W         = 8
) (
    input  wire                   refclk,
    input  wire                   rst,
    pll_lock_supervisor_if.master sup
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    // One timer serves every state, so it is sized for the longest window.
    localparam int c_TMAX_A  = (RST_CYCLES > LOCK_TIMEOUT) ? RST_CYCLES : LOCK_TIMEOUT;
    localparam int c_TMAX    = (c_TMAX_A > STABLE_CYCLES) ? c_TMAX_A : STABLE_CYCLES;
    localparam int c_TIMER_W = $clog2(c_TMAX + 1);

    localparam logic [c_TIMER_W-1:0] c_RST_LAST    = c_TIMER_W'(RST_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_LOCK_LAST   = c_TIMER_W'(LOCK_TIMEOUT - 1);
    localparam logic [c_TIMER_W-1:0] c_STABLE_LAST = c_TIMER_W'(STABLE_CYCLES - 1);
    localparam logic [c_TIMER_W-1:0] c_TIMER_MAX   = {c_TIMER_W{1'b1}};
    localparam logic [c_TIMER_W-1:0] c_TIMER_ONE   = c_TIMER_W'(1);
    localparam logic [CNT_W-1:0]     c_CNT_MAX     = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0]     c_CNT_ONE     = CNT_W'(1);

    typedef enum logic [2:0] {
        S_RESET_PLL = 3'd0,
        S_WAIT_LOCK = 3'd1,
        S_STABLE    = 3'd2,
        S_RUN       = 3'd3,
        S_FAIL      = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Registers and next-state wires
    // ------------------------------------------------------------------------
    state_t                 r_state;
    logic [c_TIMER_W-1:0]   r_timer;
    logic [CNT_W-1:0]       r_retry_cnt;
    logic [CNT_W-1:0]       r_loss_cnt;
    logic                   r_pll_rst;
    logic                   r_sys_rst;
    logic                   r_ready;
    logic                   r_fail;
    logic                   r_lk_meta;
    logic                   r_lk;

    state_t                 w_state_nxt;
    logic                   w_timer_clr;
    logic [c_TIMER_W-1:0]   w_timer_nxt;
    logic [CNT_W-1:0]       w_retry_nxt;
    logic [CNT_W-1:0]       w_loss_nxt;
    logic [CNT_W-1:0]       w_retry_inc;
    logic [CNT_W-1:0]       w_loss_inc;

    // ------------------------------------------------------------------------
    // pll_locked synchroniser: two flops, no filtering beyond that.
    // ------------------------------------------------------------------------
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_lk_meta <= 1'b0;
            r_lk      <= 1'b0;
        end else begin
            r_lk_meta <= sup.pll_locked;
            r_lk      <= r_lk_meta;
        end
    end

    // Saturating increments; counters stick at all-ones and never wrap.
    assign w_retry_inc = (r_retry_cnt == c_CNT_MAX) ? r_retry_cnt : r_retry_cnt + c_CNT_ONE;
    assign w_loss_inc  = (r_loss_cnt  == c_CNT_MAX) ? r_loss_cnt  : r_loss_cnt  + c_CNT_ONE;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        w_retry_nxt = r_retry_cnt;
        w_loss_nxt  = r_loss_cnt;
        w_timer_clr = 1'b0;

        if (sup.restart) begin
            // Restart overrides everything, even while already in RESET_PLL:
            // the timer restarts so the PLL always gets a full-width reset.
            w_state_nxt = S_RESET_PLL;
            w_retry_nxt = '0;
            w_timer_clr = 1'b1;
        end else begin
            case (r_state)
                S_RESET_PLL: begin
                    if (r_timer == c_RST_LAST) begin
                        w_state_nxt = S_WAIT_LOCK;
                    end
                end
                S_WAIT_LOCK: begin
                    if (r_lk) begin
                        w_state_nxt = S_STABLE;
                    end else if (r_timer == c_LOCK_LAST) begin
                        w_retry_nxt = w_retry_inc;
                        // Compare in 32 bits so a MAX_RETRIES beyond the
                        // counter range is never matched by truncation.
                        if (32'(w_retry_inc) == 32'(MAX_RETRIES)) begin
                            w_state_nxt = S_FAIL;
                        end else begin
                            w_state_nxt = S_RESET_PLL;
                        end
                    end
                end
                S_STABLE: begin
                    if (!r_lk) begin
                        w_state_nxt = S_WAIT_LOCK;
                    end else if (r_timer == c_STABLE_LAST) begin
                        w_state_nxt = S_RUN;
                    end
                end
                S_RUN: begin
                    // Any low sample of the synchronised lock is a loss.
                    if (!r_lk) begin
                        w_loss_nxt  = w_loss_inc;
                        w_state_nxt = S_RESET_PLL;
                    end
                end
                S_FAIL: begin
                    w_state_nxt = S_FAIL;
                end
                default: begin
                    w_state_nxt = S_RESET_PLL;
                end
            endcase

            if (w_state_nxt != r_state) begin
                w_timer_clr = 1'b1;
            end
        end

        // A successful lock forgives earlier timeouts.
        if ((w_state_nxt == S_RUN) && (r_state != S_RUN)) begin
            w_retry_nxt = '0;
        end
    end

    // The timer holds at all-ones in the open-ended states (RUN, FAIL).
    always_comb begin
        w_timer_nxt = r_timer;
        if (w_timer_clr) begin
            w_timer_nxt = '0;
        end else if (r_timer != c_TIMER_MAX) begin
            w_timer_nxt = r_timer + c_TIMER_ONE;
        end
    end

    // ------------------------------------------------------------------------
    // State register and registered outputs. Outputs are decoded from the
    // next state so they change on the same edge that changes the state.
    // ------------------------------------------------------------------------
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RESET_PLL;
            r_timer     <= '0;
            r_retry_cnt <= '0;
            r_loss_cnt  <= '0;
            r_pll_rst   <= 1'b1;
            r_sys_rst   <= 1'b1;
            r_ready     <= 1'b0;
            r_fail      <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_timer     <= w_timer_nxt;
            r_retry_cnt <= w_retry_nxt;
            r_loss_cnt  <= w_loss_nxt;
            r_pll_rst   <= (w_state_nxt == S_RESET_PLL) || (w_state_nxt == S_FAIL);
            r_sys_rst   <= (w_state_nxt != S_RUN);
            r_ready     <= (w_state_nxt == S_RUN);
            r_fail      <= (w_state_nxt == S_FAIL);
        end
    end

    assign sup.pll_rst   = r_pll_rst;
    assign sup.sys_rst   = r_sys_rst;
    assign sup.ready     = r_ready;
    assign sup.fail      = r_fail;
    assign sup.retry_cnt = r_retry_cnt;
    assign sup.loss_cnt  = r_loss_cnt;

endmodule

`default_nettype wire

// File: tb/tb_pll_lock_supervisor.sv
// ============================================================================
// Module      : tb_pll_lock_supervisor
// Description : Directed bench for pll_lock_supervisor with short windows
//               (RST_CYCLES=4, LOCK_TIMEOUT=20, STABLE_CYCLES=8,
//               MAX_RETRIES=2, CNT_W=2). Cycle k is the k-th refclk period
//               after rst release; cycle 0 holds the reset values. Inputs
//               change and outputs are sampled 1 ns after each rising edge.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pll_lock_supervisor;

    localparam int RST_CYCLES    = 4;
    localparam int LOCK_TIMEOUT  = 20;
    localparam int STABLE_CYCLES = 8;
    localparam int MAX_RETRIES   = 2;
    localparam int CNT_W         = 2;

    logic refclk = 1'b0;
    logic rst    = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;

    pll_lock_supervisor_if #(.CNT_W(CNT_W)) sup_if ();

    pll_lock_supervisor #(
        .RST_CYCLES    (RST_CYCLES),
        .LOCK_TIMEOUT  (LOCK_TIMEOUT),
        .STABLE_CYCLES (STABLE_CYCLES),
        .MAX_RETRIES   (MAX_RETRIES),
        .CNT_W         (CNT_W)
    ) u_dut (
        .refclk (refclk),
        .rst    (rst),
        .sup    (sup_if)
    );

    always #5 refclk = ~refclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge refclk);
        #1;
        cyc++;
    endtask

    task automatic run_to(input int k);
        while (cyc < k) step();
    endtask

    // Hold rst for one edge, check reset values, release: now in cycle 0.
    task automatic apply_reset();
        rst = 1'b1;
        sup_if.pll_locked = 1'b0;
        sup_if.restart    = 1'b0;
        @(posedge refclk);
        #1;
        check("rst_pll_rst", sup_if.pll_rst,   1);
        check("rst_sys_rst", sup_if.sys_rst,   1);
        check("rst_ready",   sup_if.ready,     0);
        check("rst_fail",    sup_if.fail,      0);
        check("rst_retry",   sup_if.retry_cnt, 0);
        check("rst_loss",    sup_if.loss_cnt,  0);
        rst = 1'b0;
        cyc = 0;
    endtask

    task automatic wait_ready(input int budget);
        int n;
        n = 0;
        while (!sup_if.ready && n < budget) begin
            step();
            n++;
        end
        check("wait_ready", sup_if.ready, 1);
    endtask

    initial begin
        #100000;
        check("watchdog", 0, 1);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        sup_if.pll_locked = 1'b0;
        sup_if.restart    = 1'b0;
        #2;

        // ---- 1: clean lock. Pin high at 6, lk at 8, STABLE 9..16, RUN 17.
        apply_reset();
        run_to(3);
        check("t1_pll_rst_c3", sup_if.pll_rst, 1);
        run_to(4);
        check("t1_pll_rst_c4", sup_if.pll_rst, 0);
        run_to(6);
        sup_if.pll_locked = 1'b1;
        run_to(16);
        check("t1_ready_c16",   sup_if.ready,   0);
        check("t1_sys_rst_c16", sup_if.sys_rst, 1);
        run_to(17);
        check("t1_ready_c17",   sup_if.ready,     1);
        check("t1_sys_rst_c17", sup_if.sys_rst,   0);
        check("t1_retry_c17",   sup_if.retry_cnt, 0);
        check("t1_pll_rst_c17", sup_if.pll_rst,   0);

        // ---- 2: no lock. WAIT 4..23, timeout -> RESET 24..27, WAIT 28..47,
        //      second timeout -> FAIL at 48.
        apply_reset();
        run_to(23);
        check("t2_pll_rst_c23", sup_if.pll_rst,   0);
        check("t2_retry_c23",   sup_if.retry_cnt, 0);
        run_to(24);
        check("t2_retry_c24",   sup_if.retry_cnt, 1);
        check("t2_pll_rst_c24", sup_if.pll_rst,   1);
        run_to(28);
        check("t2_pll_rst_c28", sup_if.pll_rst,   0);
        run_to(47);
        check("t2_retry_c47",   sup_if.retry_cnt, 1);
        check("t2_fail_c47",    sup_if.fail,      0);
        run_to(48);
        check("t2_fail_c48",    sup_if.fail,      1);
        check("t2_retry_c48",   sup_if.retry_cnt, 2);
        check("t2_pll_rst_c48", sup_if.pll_rst,   1);
        run_to(60);
        check("t2_fail_c60",    sup_if.fail,      1);
        check("t2_pll_rst_c60", sup_if.pll_rst,   1);
        check("t2_ready_c60",   sup_if.ready,     0);
        sup_if.restart = 1'b1;
        step();
        sup_if.restart = 1'b0;
        check("t2_fail_c61",    sup_if.fail,      0);
        check("t2_retry_c61",   sup_if.retry_cnt, 0);
        check("t2_pll_rst_c61", sup_if.pll_rst,   1);
        run_to(64);
        check("t2_pll_rst_c64", sup_if.pll_rst,   1);
        run_to(65);
        check("t2_pll_rst_c65", sup_if.pll_rst,   0);

        // ---- 3: pin low during cycle 12 -> lk low in cycle 14 (STABLE
        //      timer=5) -> WAIT 15, STABLE 16..23, RUN 24.
        apply_reset();
        run_to(6);
        sup_if.pll_locked = 1'b1;
        run_to(12);
        sup_if.pll_locked = 1'b0;
        step();
        sup_if.pll_locked = 1'b1;
        run_to(17);
        check("t3_ready_c17",   sup_if.ready,   0);
        run_to(23);
        check("t3_ready_c23",   sup_if.ready,   0);
        check("t3_sys_rst_c23", sup_if.sys_rst, 1);
        run_to(24);
        check("t3_ready_c24",   sup_if.ready,   1);
        check("t3_sys_rst_c24", sup_if.sys_rst, 0);

        // ---- 4: RUN glitch at cycle 26 -> sys_rst at 29, pll_rst 29..32,
        //      WAIT 33, STABLE 34..41, RUN 42.
        run_to(26);
        sup_if.pll_locked = 1'b0;
        step();
        sup_if.pll_locked = 1'b1;
        run_to(28);
        check("t4_ready_c28",   sup_if.ready,    1);
        run_to(29);
        check("t4_ready_c29",   sup_if.ready,    0);
        check("t4_sys_rst_c29", sup_if.sys_rst,  1);
        check("t4_pll_rst_c29", sup_if.pll_rst,  1);
        check("t4_loss_c29",    sup_if.loss_cnt, 1);
        run_to(32);
        check("t4_pll_rst_c32", sup_if.pll_rst,  1);
        run_to(33);
        check("t4_pll_rst_c33", sup_if.pll_rst,  0);
        run_to(41);
        check("t4_ready_c41",   sup_if.ready,    0);
        run_to(42);
        check("t4_ready_c42",   sup_if.ready,     1);
        check("t4_loss_c42",    sup_if.loss_cnt,  1);
        check("t4_retry_c42",   sup_if.retry_cnt, 0);

        // ---- 5: losses 2..5 with CNT_W=2 -> loss_cnt 2,3,3,3.
        for (int i = 2; i <= 5; i++) begin
            sup_if.pll_locked = 1'b0;
            step();
            sup_if.pll_locked = 1'b1;
            step();
            step();
            check("t5_ready_drop", sup_if.ready,    0);
            check("t5_loss",       sup_if.loss_cnt, (i > 3) ? 3 : i);
            wait_ready(40);
        end
        sup_if.restart = 1'b1;
        step();
        sup_if.restart = 1'b0;
        check("t5_loss_restart",  sup_if.loss_cnt, 3);
        check("t5_pll_rst_rstrt", sup_if.pll_rst,  1);
        check("t5_ready_rstrt",   sup_if.ready,    0);

        // ---- 6a: rst asserted mid-WAIT_LOCK acts without a clock edge.
        apply_reset();
        run_to(30);
        check("t6_retry_c30",   sup_if.retry_cnt, 1);
        check("t6_pll_rst_c30", sup_if.pll_rst,   0);
        rst = 1'b1;
        #1;
        check("t6_async_pll_rst", sup_if.pll_rst,   1);
        check("t6_async_sys_rst", sup_if.sys_rst,   1);
        check("t6_async_retry",   sup_if.retry_cnt, 0);

        // ---- 6b: restart coincident with the second timeout (cycle 47).
        apply_reset();
        run_to(47);
        check("t6_retry_c47", sup_if.retry_cnt, 1);
        sup_if.restart = 1'b1;
        step();
        sup_if.restart = 1'b0;
        check("t6_fail_c48",    sup_if.fail,      0);
        check("t6_retry_c48",   sup_if.retry_cnt, 0);
        check("t6_pll_rst_c48", sup_if.pll_rst,   1);
        run_to(51);
        check("t6_pll_rst_c51", sup_if.pll_rst,   1);
        run_to(52);
        check("t6_pll_rst_c52", sup_if.pll_rst,   0);
        check("t6_fail_c52",    sup_if.fail,      0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
